// File: rtl/instr_enc_loader.sv
// RV32I instruction encoder and program loader: packs decoded fields into
// instruction words and writes them to consecutive memory words.
module instr_enc_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              last,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_J   = 3'd4,
    FMT_U   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_t;

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

  function automatic fmt_t fmt_of(input logic [6:0] opc);
    case (opc)
      7'b0110011:                         fmt_of = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: fmt_of = FMT_I;
      7'b0100011:                         fmt_of = FMT_S;
      7'b1100011:                         fmt_of = FMT_B;
      7'b1101111:                         fmt_of = FMT_J;
      7'b0010111, 7'b0110111:             fmt_of = FMT_U;
      default:                            fmt_of = FMT_ILL;
    endcase
  endfunction

  // B and J drop imm[0]; their offset bits are scattered as the core decodes them.
  function automatic logic [31:0] pack_word(
    input fmt_t        f,
    input logic [6:0]  opc,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    case (f)
      FMT_R:   pack_word = {f7, s2, s1, f3, d, opc};
      FMT_I:   pack_word = {im[11:0], s1, f3, d, opc};
      FMT_S:   pack_word = {im[11:5], s2, s1, f3, im[4:0], opc};
      FMT_B:   pack_word = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], opc};
      FMT_J:   pack_word = {im[20], im[10:1], im[11], im[19:12], d, opc};
      FMT_U:   pack_word = {im[31:12], d, opc};
      default: pack_word = 32'h0000_0000;
    endcase
  endfunction

  state_t          state_r;
  logic            in_ready_r;
  logic            mem_we_r;
  logic [31:0]     mem_addr_r;
  logic [31:0]     mem_wdata_r;
  logic [ADDR_W:0] count_r;
  logic            done_r;
  logic            err_r;
  logic [1:0]      err_code_r;
  logic            last_r;

  fmt_t            fmt_s;
  logic            legal_s;
  logic [31:0]     word_s;
  logic [ADDR_W:0] count_inc_s;

  // Format decode and word packing of the presented field set.
  always_comb begin
    fmt_s       = fmt_of(op);
    legal_s     = (fmt_s != FMT_ILL);
    word_s      = pack_word(fmt_s, op, rd, rs1, rs2, funct3, funct7, imm);
    count_inc_s = count_r + ONE_COUNT;
  end

  // Loader FSM with all outputs registered; start outranks everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE_ADDR;
      mem_wdata_r <= 32'h0000_0000;
      count_r     <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'b00;
      last_r      <= 1'b0;
    end else if (start) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= BASE_ADDR;
      count_r     <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'b00;
      last_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            if (legal_s) begin
              mem_wdata_r <= word_s;
              last_r      <= last;
              mem_we_r    <= 1'b1;
              state_r     <= WRITE;
            end else begin
              err_r       <= 1'b1;
              err_code_r  <= 2'b01;
              state_r     <= ERROR;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        WRITE: begin
          // Commit edge: mem_addr moves on so it always names the next free word.
          if (mem_ready) begin
            mem_we_r   <= 1'b0;
            count_r    <= count_inc_s;
            mem_addr_r <= mem_addr_r + 32'd4;
            if (last_r) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else if (count_inc_s == FULL_COUNT) begin
              err_r      <= 1'b1;
              err_code_r <= 2'b10;
              state_r    <= ERROR;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= IDLE;
            end
          end
        end
        DONE: begin
          in_ready_r <= 1'b0;
        end
        ERROR: begin
          in_ready_r <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          mem_we_r   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign count     = count_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_code  = err_code_r;

endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed and randomized bench for instr_enc_loader (depth 4 words so overflow
// is reachable); expected words come from an arithmetic RV32I encoding model.
module tb_instr_enc_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, last;
  logic [6:0]  op, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [AW:0] count;
  logic        done, err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int m_count = 0;
  bit m_stopped = 1'b0;

  instr_enc_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .last(last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal_ref(input logic [6:0] o);
    return o inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37};
  endfunction

  // Reference encoding from the field placement rules using shifts and masks.
  function automatic logic [31:0] encode_ref(input logic [6:0] o, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    int unsigned i, uo, ud, u1, u2, u3, u7, common;
    i = im; uo = o; ud = d; u1 = s1; u2 = s2; u3 = f3; u7 = f7;
    common = (u1 << 15) | (u3 << 12) | uo;
    case (o)
      7'h33:               return (u7 << 25) | (u2 << 20) | common | (ud << 7);
      7'h13, 7'h03, 7'h67: return ((i & 32'hFFF) << 20) | common | (ud << 7);
      7'h23: return (((i >> 5) & 32'h7F) << 25) | (u2 << 20) | common | ((i & 32'h1F) << 7);
      7'h63: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | (u2 << 20)
                    | common | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7);
      7'h6F: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                    | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12)
                    | (ud << 7) | uo;
      7'h17, 7'h37:        return (i & 32'hFFFF_F000) | (ud << 7) | uo;
      default:             return 32'h0;
    endcase
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_count = 0;
    m_stopped = 1'b0;
    chk("start_ready", in_ready, 1);
    chk("start_count", count, 0);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_code", err_code, 0);
    chk("start_we", mem_we, 0);
    chk("start_addr", mem_addr, BASE);
  endtask

  // Offer one field set, hold mem_ready low for 'stall' cycles, then commit.
  task automatic send(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input logic lst, input int stall, input logic [31:0] exp_word);
    int waited;
    bit lg, full;
    logic [31:0] exp_addr;
    waited = 0;
    lg = is_legal_ref(o);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", in_ready, 1);
    if (!in_ready) return;
    op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im; last = lst;
    in_valid = 1'b1;
    mem_ready = (stall == 0);
    exp_addr = BASE + 32'(4 * m_count);
    @(negedge clk);
    in_valid = 1'b0;
    if (!lg) begin
      chk("ill_we", mem_we, 0);
      chk("ill_err", err, 1);
      chk("ill_code", err_code, 2'b01);
      chk("ill_ready", in_ready, 0);
      chk("ill_count", count, m_count);
      m_stopped = 1'b1;
      return;
    end
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, exp_addr);
    chk("wr_data", mem_wdata, exp_word);
    chk("wr_ready", in_ready, 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_we", mem_we, 1);
      chk("stall_addr", mem_addr, exp_addr);
      chk("stall_data", mem_wdata, exp_word);
      chk("stall_ready", in_ready, 0);
      chk("stall_count", count, m_count);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    m_count++;
    full = (!lst) && (m_count == DEPTH);
    chk("cm_we", mem_we, 0);
    chk("cm_count", count, m_count);
    chk("cm_addr", mem_addr, BASE + 32'(4 * m_count));
    chk("cm_done", done, lst);
    chk("cm_err", err, full);
    chk("cm_code", err_code, full ? 2'b10 : 2'b00);
    chk("cm_ready", in_ready, !(lst || full));
    if (lst || full) m_stopped = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0; mem_ready = 1'b1;
    op = 7'h00; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_data", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);

    // Legal formats back to back with mem_ready high
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 0, 32'h0050_0093);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 0, 32'h0020_81B3);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 0, 32'h1234_52B7);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("done_hold", done, 1);
    chk("done_noacc", mem_we, 0);
    chk("done_ready", in_ready, 0);

    // Immediate scrambling; first write stalled for 5 cycles
    pulse_start();
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 5, 32'h0020_A423);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 0, 32'hFE00_0EE3);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1, 0, 32'h0100_00EF);

    // Illegal opcode then recovery
    pulse_start();
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0, 32'h0);
    @(negedge clk);
    chk("ill_sticky", err_code, 2'b01);
    pulse_start();

    // Overflow after DEPTH words without last
    for (int k = 0; k < DEPTH; k++)
      send(7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1'b0, 0,
           encode_ref(7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k)));
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ovf_nowrite", mem_we, 0);
      chk("ovf_count", count, DEPTH);
      chk("ovf_code", err_code, 2'b10);
    end
    in_valid = 1'b0;

    // start in the same cycle as mem_ready during WRITE
    pulse_start();
    op = 7'h13; rd = 5'd1; imm = 32'd5; last = 1'b0; in_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ab_we", mem_we, 1);
    start = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_count", count, 0);
    chk("ab_we0", mem_we, 0);
    chk("ab_ready", in_ready, 1);
    @(negedge clk);
    chk("ab_noretry", mem_we, 0);
    m_count = 0;

    // Reset in the middle of a stalled second write
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 0, 32'h0070_0113);
    op = 7'h13; rd = 5'd3; imm = 32'd9; in_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_we", mem_we, 1);
    chk("rw_addr", mem_addr, BASE + 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_we0", mem_we, 0);
    chk("rw_addr0", mem_addr, BASE);
    chk("rw_data0", mem_wdata, 0);
    chk("rw_count0", count, 0);
    chk("rw_ready0", in_ready, 0);
    chk("rw_flags", {done, err, err_code}, 0);
    rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("rw_rel", in_ready, 1);

    // Randomized programs against the encoding and loader model
    for (int p = 0; p < 12; p++) begin
      int len;
      pulse_start();
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        logic [6:0] o;
        logic [4:0] d, s1, s2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] im;
        if (m_stopped) break;
        if ($urandom_range(0, 9) == 0) begin
          do o = 7'($urandom_range(0, 127)); while (is_legal_ref(o));
        end else begin
          case ($urandom_range(0, 8))
            0: o = 7'h33; 1: o = 7'h13; 2: o = 7'h03; 3: o = 7'h67; 4: o = 7'h23;
            5: o = 7'h63; 6: o = 7'h6F; 7: o = 7'h17; default: o = 7'h37;
          endcase
        end
        d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
        f3 = 3'($urandom); f7 = 7'($urandom); im = $urandom;
        send(o, d, s1, s2, f3, f7, im, (k == len - 1), $urandom_range(0, 2),
             encode_ref(o, d, s1, s2, f3, f7, im));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_enc_loader.md
# instr_enc_loader

Sequential RV32I instruction encoder and program loader, the inverse of the processor's opcode/immediate-format decode. It accepts decoded instruction fields over a valid/ready handshake and packs them into a 32-bit instruction word using the same opcode-to-format mapping the core decodes. It then writes the words to consecutive instruction-memory locations through a stall-capable write port. It sits between the bench or boot controller and the unified memory of the multicycle core.

## Interface
- ADDR_W, 8: word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000: byte address of the first word, word-aligned.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset. One clock domain.
- start  in  1  pulse: clear count, done and err, and return to IDLE.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept a field set.
- op  in  7  opcode.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3; funct7  in  7.
- imm  in  32  immediate, already sign-extended and unscaled (a byte offset for B and J).
- last  in  1  marks the final instruction of the program.
- mem_we  out  1  write request.
- mem_addr  out  32  byte address, BASE_ADDR + 4*count.
- mem_wdata  out  32  encoded word.
- mem_ready  in  1  memory accepts the write this cycle.
- count  out  ADDR_W+1  words written so far.
- done  out  1  the last instruction has been written.
- err  out  1  sticky error flag.
- err_code  out  2  01 = illegal opcode, 10 = overflow.

## Operation
- Format select, applied combinationally on op:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - J: 1101111.
  - U: 0010111, 0110111.
  - Any other opcode is illegal.
- Word packing:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - U: {imm[31:12], rd, op}.
  - Fields not used by a format are ignored. imm[0] is ignored for B and J. No range check is done on imm.
- FSM states: IDLE, WRITE, DONE, ERROR.
  - IDLE: in_ready=1.
    - Accept (in_valid & in_ready) with a legal op: latch the word into mem_wdata, latch last, go to WRITE.
    - Accept with an illegal op: err=1, err_code=01, go to ERROR. Nothing is written.
  - WRITE: mem_we=1, with mem_addr and mem_wdata held stable until mem_ready.
    - On mem_ready, count increments.
    - Then: if last was latched, go to DONE.
    - Otherwise, if count has reached 2^ADDR_W, go to ERROR with err_code=10.
    - Otherwise go to IDLE.
  - DONE: done=1, in_ready=0. Holds until start.
  - ERROR: err=1, in_ready=0. Holds until start. err_code keeps its first cause.
- start has priority over every other event in the same cycle, including an in-progress write.
  - Next cycle: state IDLE, count=0, done=0, err=0, err_code=00, mem_we=0.
  - An aborted write is not retried.

## Timing
- Reset values (rst_n low at a clock edge):
  - in_ready=0 during reset, then 1 from the first cycle after reset releases (state IDLE).
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, err=0, err_code=00.
- A reset asserted during WRITE drops mem_we at that same edge. No partial state survives.
- Latency and throughput:
  - Field set accepted at cycle N: mem_we=1 from N+1.
  - With mem_ready=1 at N+1, the write commits at N+1 and in_ready=1 at N+2.
  - Peak throughput is one word per 2 cycles.
- in_ready is registered and depends only on state. It never depends combinationally on in_valid.
- mem_ready low stalls WRITE indefinitely with all outputs held.
- count and mem_addr update on the commit edge, so mem_addr always addresses the next free word.
- done and err are registered. Each rises the cycle after its entering event.

## Test plan
- Legal formats: send addi x1,x0,5, then add x3,x1,x2, then lui x5,0x12345 (last=1), with mem_ready tied high. Required:
  - Writes of 0x00500093, 0x002081B3, 0x123452B7 to byte addresses 0x0, 0x4, 0x8.
  - count=3 and done=1 the cycle after the third commit.
- Immediate scrambling: send sw x2,8(x1), then beq x0,x0,-4, then jal x1,16. Required words: 0x0020A423, 0xFE000EE3, 0x010000EF.
- Stall: hold mem_ready low for 5 cycles during the first write. Required:
  - mem_we, mem_addr and mem_wdata stay stable and in_ready stays 0.
  - The commit occurs on the cycle mem_ready rises.
- Illegal opcode: send op 7'b1111111. Required:
  - No mem_we pulse; err=1, err_code=01, in_ready=0.
  - A following start returns to IDLE with count=0.
- Overflow: with ADDR_W=2, send 4 instructions with last=0. Required:
  - 4 writes, to byte addresses 0x0 through 0xC.
  - Then err=1 and err_code=10 with count=4, and no fifth write.
- Abort and reset: assert start in the same cycle as mem_ready during WRITE. Required:
  - count stays 0 and mem_we=0 the next cycle.
  - Repeat with rst_n low mid-write: all outputs take their reset values at that edge.
